dmem_sram_bridge: RTL

Data-side bridge between the CPU datapath's MEM stage and an SRAM-like split-handshake data bus (req/addr_ok/data_ok). It turns the MEM stage's single-cycle memory enable into a two-phase bus transaction and raises `stallreq_from_mem` until the access completes. It holds load data stable while other hazards keep the pipeline stalled, so each MEM-stage instruction issues exactly one bus transaction.

---
 rtl/dmem_sram_bridge_if.sv | 21 ++
 rtl/dmem_sram_bridge.sv | 105 ++++++++++
 2 files changed

// File: rtl/dmem_sram_bridge_if.sv
// rtl/dmem_sram_bridge_if.sv - SRAM-like split-handshake data bus (req/addr_ok/data_ok)
interface dmem_sram_bridge_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/dmem_sram_bridge.sv
// rtl/dmem_sram_bridge.sv - MEM-stage to SRAM-like bus bridge, one transaction per instruction
module dmem_sram_bridge (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cpu_en,
    input  logic                       cpu_we,
    input  logic [31:0]                cpu_addr,
    input  logic [1:0]                 cpu_size,
    input  logic [31:0]                cpu_wdata,
    input  logic                       cpu_stall,
    output logic [31:0]                cpu_rdata,
    output logic                       stallreq_from_mem,
    dmem_sram_bridge_if.master         bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ADDR = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        wr_q,    wr_d;
    logic [1:0]  size_q,  size_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        data_done;

    assign data_done = (state_q == WAIT_DATA) && bus.data_data_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        wr_d           = wr_q;
        size_d         = size_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        bus.data_req   = 1'b0;
        bus.data_wr    = wr_q;
        bus.data_size  = size_q;
        bus.data_addr  = addr_q;
        bus.data_wdata = wdata_q;

        unique case (state_q)
            IDLE: begin
                // First cycle goes straight to the bus so the best case costs one stall cycle.
                bus.data_req   = cpu_en;
                bus.data_wr    = cpu_we;
                bus.data_size  = cpu_size;
                bus.data_addr  = cpu_addr;
                bus.data_wdata = cpu_wdata;
                if (cpu_en) begin
                    wr_d    = cpu_we;
                    size_d  = cpu_size;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = bus.data_addr_ok ? WAIT_DATA : WAIT_ADDR;
                end
            end
            WAIT_ADDR: begin
                bus.data_req = 1'b1;
                if (bus.data_addr_ok) begin
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (bus.data_data_ok) begin
                    rdata_d = bus.data_rdata;
                    state_d = cpu_stall ? DONE : IDLE;
                end
            end
            DONE: begin
                // Pipeline still frozen by another hazard: hold data, never re-issue.
                if (!cpu_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_rdata         = data_done ? bus.data_rdata : rdata_q;
    assign stallreq_from_mem = cpu_en && (state_q != DONE) && !data_done;

endmodule
